// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;

  // Width of the word index for an array of the given depth.
  function automatic int idx_width(input int depth_words);
    return $clog2(depth_words);
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Load/store bus between the pipeline MEM stage (master) and the data memory (slave).
// Handshake: master raises req with we/addr/wd/be and holds req until the one-cycle
// ready pulse; rd/err are meaningful only while ready=1; stall freezes the pipeline.
interface dmem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [3:0]  be;
  logic [31:0] rd;
  logic        ready;
  logic        err;
  logic        stall;

  modport master (output req, we, addr, wd, be, input rd, ready, err, stall);
  modport slave  (input req, we, addr, wd, be, output rd, ready, err, stall);
endinterface

// File: rtl/dmem_array.sv
// Word-organised data array: synchronous byte-enable write, combinational read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int IDX_W       = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wd,
  input  logic [3:0]       be,
  output logic [31:0]      rd
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  assign rd = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: latches a MEM-stage request, waits LATENCY cycles,
// commits the access, then returns a one-cycle ready pulse with rd/err.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus,
  output state_t state_dbg
);

  localparam int         IDX_W    = idx_width(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wd;
  logic [3:0]  lat_be;
  logic [31:0] rd_q;
  logic        ready_q;
  logic        err_q;

  logic             misaligned;
  logic             out_of_range;
  logic             bad;
  logic             commit;
  logic             mem_we;
  logic [IDX_W-1:0] idx;
  logic [31:0]      mem_rd;

  // Error checks look only at the latched request, so late input changes are inert.
  assign misaligned   = (lat_addr[1:0] != 2'b00) && (lat_be != 4'b0000);
  assign out_of_range = (lat_addr[31:IDX_W+2] != '0);
  assign bad          = misaligned | out_of_range;
  assign commit       = (state == BUSY) && (cnt == 4'd0);
  assign mem_we       = commit && lat_we && !bad;
  assign idx          = lat_addr[IDX_W+1:2];

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk (clk),
    .we  (mem_we),
    .idx (idx),
    .wd  (lat_wd),
    .be  (lat_be),
    .rd  (mem_rd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      lat_we   <= 1'b0;
      lat_addr <= 32'd0;
      lat_wd   <= 32'd0;
      lat_be   <= 4'd0;
      rd_q     <= 32'd0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req) begin
            lat_we   <= bus.we;
            lat_addr <= bus.addr;
            lat_wd   <= bus.wd;
            lat_be   <= bus.be;
            cnt      <= CNT_INIT;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            ready_q <= 1'b1;
            err_q   <= bad;
            rd_q    <= (!lat_we && !bad) ? mem_rd : 32'd0;
            state   <= RESP;
          end
        end
        RESP: begin
          // The req still high here belongs to the request just completed.
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          rd_q    <= 32'd0;
          state   <= IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          rd_q    <= 32'd0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.rd    = rd_q;
  assign bus.ready = ready_q;
  assign bus.err   = err_q;
  assign bus.stall = (state == BUSY) | ((state == IDLE) & bus.req);
  assign state_dbg = state;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance A uses LATENCY=2, instance B LATENCY=1.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [3:0]  be;
  state_t      a_state;
  state_t      b_state;

  int n_checks;
  int n_errors;
  logic [31:0] exp_q[$];

  dmem_if a_if ();
  dmem_if b_if ();

  assign a_if.req  = req & ~sel;
  assign a_if.we   = we;
  assign a_if.addr = addr;
  assign a_if.wd   = wd;
  assign a_if.be   = be;
  assign b_if.req  = req & sel;
  assign b_if.we   = we;
  assign b_if.addr = addr;
  assign b_if.wd   = wd;
  assign b_if.be   = be;

  logic [31:0] s_rd;
  logic        s_ready;
  logic        s_err;
  logic        s_stall;
  assign s_rd    = sel ? b_if.rd    : a_if.rd;
  assign s_ready = sel ? b_if.ready : a_if.ready;
  assign s_err   = sel ? b_if.err   : a_if.err;
  assign s_stall = sel ? b_if.stall : a_if.stall;

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .bus       (a_if.slave),
    .state_dbg (a_state)
  );

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(1)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .bus       (b_if.slave),
    .state_dbg (b_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Drives one request and holds req until ready; busy_a replaces addr from cycle 1 on.
  task automatic do_access(input logic s, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] b,
                           input logic [31:0] busy_a,
                           output logic [31:0] r, output logic e,
                           output int rc, output logic [15:0] sm);
    logic seen;
    @(posedge clk); #1;
    sel = s; req = 1'b1; we = w; addr = a; wd = d; be = b;
    rc = -1; sm = '0; r = '0; e = 1'b0; seen = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      sm[c] = s_stall;
      if (s_ready) begin
        r = s_rd; e = s_err; rc = c; seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
      if (c == 0) addr = busy_a;
    end
    check("ready_seen", {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic store_a(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                         output logic e);
    logic [31:0] r; int rc; logic [15:0] sm;
    do_access(1'b0, 1'b1, a, d, b, a, r, e, rc, sm);
  endtask

  task automatic load_a(input logic [31:0] a, output logic [31:0] r, output logic e);
    int rc; logic [15:0] sm;
    do_access(1'b0, 1'b0, a, 32'd0, 4'hF, a, r, e, rc, sm);
  endtask

  initial begin
    logic [31:0] r;
    logic        e;
    int          rc;
    logic [15:0] sm;
    logic [5:0]  rmask;
    logic [5:0]  smask;

    n_checks = 0; n_errors = 0;
    rst = 1'b0; sel = 1'b0; req = 1'b0; we = 1'b0;
    addr = '0; wd = '0; be = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, a_if.ready}, 32'd0);
    check("rst_err",   {31'd0, a_if.err},   32'd0);
    check("rst_rd",    a_if.rd,             32'd0);
    check("rst_stall", {31'd0, a_if.stall}, 32'd0);
    check("rst_state", {30'd0, a_state},    32'd0);
    rst = 1'b1;

    // store then load with LATENCY=2
    do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h10, r, e, rc, sm);
    check("st_ready_cycle", rc, 32'd3);
    check("st_stall_mask", {28'd0, sm[3:0]}, 32'h7);
    check("st_err", {31'd0, e}, 32'd0);
    check("st_rd", r, 32'd0);
    do_access(1'b0, 1'b0, 32'h10, 32'd0, 4'hF, 32'h10, r, e, rc, sm);
    check("ld_ready_cycle", rc, 32'd3);
    check("ld_rd", r, 32'hDEADBEEF);
    check("ld_err", {31'd0, e}, 32'd0);
    @(negedge clk);
    check("idle_rd", a_if.rd, 32'd0);

    // byte enables
    store_a(32'h20, 32'h11223344, 4'hF, e);
    store_a(32'h20, 32'hAABBCCDD, 4'b0101, e);
    check("be_err", {31'd0, e}, 32'd0);
    load_a(32'h20, r, e);
    check("be_rd", r, 32'h11BB33DD);

    // misaligned load
    load_a(32'h13, r, e);
    check("mis_err", {31'd0, e}, 32'd1);
    check("mis_rd", r, 32'd0);

    // out-of-range store must not alias onto word 0
    store_a(32'h0,  32'h01010101, 4'hF, e);
    store_a(32'hFC, 32'h63636363, 4'hF, e);
    store_a(32'h400, 32'hFFFFFFFF, 4'hF, e);
    check("oor_err", {31'd0, e}, 32'd1);
    load_a(32'h0, r, e);
    check("oor_word0", r, 32'h01010101);
    load_a(32'hFC, r, e);
    check("oor_word63", r, 32'h63636363);
    check("oor_word63_err", {31'd0, e}, 32'd0);

    // reset in the first BUSY cycle drops the store
    store_a(32'h8, 32'h0, 4'hF, e);
    @(posedge clk); #1;
    sel = 1'b0; req = 1'b1; we = 1'b1; addr = 32'h8; wd = 32'hCAFEF00D; be = 4'hF;
    @(posedge clk); #1;
    check("mid_busy_state", {30'd0, a_state}, 32'd1);
    #2; rst = 1'b0;
    #1;
    check("mid_rst_state", {30'd0, a_state}, 32'd0);
    check("mid_rst_ready", {31'd0, a_if.ready}, 32'd0);
    req = 1'b0;
    @(negedge clk); rst = 1'b1;
    load_a(32'h8, r, e);
    check("mid_rst_word", r, 32'h00000000);

    // empty byte-enable store is a legal no-op
    store_a(32'h10, 32'h12345678, 4'b0000, e);
    check("be0_err", {31'd0, e}, 32'd0);
    load_a(32'h10, r, e);
    check("be0_rd", r, 32'hDEADBEEF);

    // address change while BUSY is ignored
    store_a(32'h14, 32'h14141414, 4'hF, e);
    do_access(1'b0, 1'b0, 32'h10, 32'd0, 4'hF, 32'h14, r, e, rc, sm);
    check("busy_addr_rd", r, 32'hDEADBEEF);

    // back-to-back loads on the LATENCY=1 instance
    do_access(1'b1, 1'b1, 32'h0, 32'hA0A0A0A0, 4'hF, 32'h0, r, e, rc, sm);
    check("b_st_ready_cycle", rc, 32'd2);
    do_access(1'b1, 1'b1, 32'h4, 32'hB4B4B4B4, 4'hF, 32'h4, r, e, rc, sm);
    exp_q.push_back(32'hA0A0A0A0);
    exp_q.push_back(32'hB4B4B4B4);
    @(posedge clk); #1;
    sel = 1'b1; req = 1'b1; we = 1'b0; addr = 32'h0; be = 4'hF;
    rmask = '0; smask = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      rmask[c] = s_ready;
      smask[c] = s_stall;
      if (s_ready) begin
        if (exp_q.size() == 0) check("b2b_extra_ready", 32'd1, 32'd0);
        else check("b2b_rd", s_rd, exp_q.pop_front());
      end
      @(posedge clk); #1;
      if (c == 2) addr = 32'h4;
    end
    req = 1'b0;
    check("b2b_ready_mask", {26'd0, rmask}, 32'h24);
    check("b2b_stall_mask", {26'd0, smask}, 32'h1B);
    check("b2b_left", exp_q.size(), 32'd0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the load/store requests the pipelined MIPS datapath issues from its MEM stage (address = ALU result, write data = forwarded rt).
- Holds a word-organised memory, models configurable access latency, and supports byte-enable writes.
- Returns read data with a one-cycle ready pulse.
- Drives a stall so the pipeline freezes while an access is outstanding.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words in the array (power of two).
- LATENCY, 2, number of BUSY cycles per access (legal range 1..15).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  1  access request; held high by the pipeline until ready.
- we  in  1  1 = store, 0 = load; sampled with req.
- addr  in  32  byte address; word index = addr[log2(DEPTH_WORDS)+1:2].
- wd  in  32  store data.
- be  in  4  byte enables; be[i] selects wd[8i+7:8i].
- rd  out  32  load data; valid only while ready=1.
- ready  out  1  one-cycle completion pulse.
- err  out  1  error flag; valid only while ready=1.
- stall  out  1  pipeline freeze request.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, cnt=0, rd=0, ready=0, err=0, and all latched request fields are cleared. Array contents are not reset; in simulation the array initialises to zero.
- States: IDLE, BUSY, RESP. cnt is a 4-bit down-counter.
- IDLE:
  - If req=1 at an edge: latch we/addr/wd/be, load cnt=LATENCY-1, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - If cnt!=0: decrement cnt.
  - If cnt==0 (commit edge): perform the access and go to RESP.
    - Load: rd <= array[idx].
    - Store: write only the bytes whose be bit is set; rd <= 0.
- RESP: ready=1, with rd/err driven from registers. Go to IDLE at the next edge. A req seen in RESP is the completing request and is ignored.
- Timing: req first sampled at edge E; ready is high in the cycle after edge E+LATENCY, i.e. LATENCY+1 cycles after req. With LATENCY=2, req sampled in cycle 0 gives ready in cycle 3.
- Back-to-back: the next request is accepted no earlier than the first IDLE edge after RESP. Throughput is one access per LATENCY+2 cycles.
- stall (combinational) = (state==BUSY) | (state==IDLE & req). stall is 0 in RESP so the pipeline advances on the same edge that ready completes.
- Errors are detected at the commit edge:
  - Misaligned: addr[1:0]!=0 and be!=0 → err=1, rd=0, no array write.
  - Out of range: addr[31:log2(DEPTH_WORDS)+2]!=0 → err=1, rd=0, no write.
  - be=4'b0000 store: legal no-op, err=0.
  - Misaligned and out-of-range together: a single err, same response.
- Request inputs are latched at acceptance. Changes to addr/wd/be while BUSY have no effect.
- Reset mid-operation: return to IDLE. A store whose commit edge has not yet occurred is never written. An already-committed store persists.
- ready and err are never high outside RESP; rd is 0 outside RESP.

Decomposition:
- Package dmem_pkg:
  - state encoding: IDLE=2'd0, BUSY=2'd1, RESP=2'd2.
  - WORD_BYTES=4.
  - helper constant for the index width, clog2(DEPTH_WORDS).
- One sub-module dmem_array:
  - DEPTH_WORDS x 32.
  - synchronous write with 4 byte enables; combinational read on index.
  - No reset.
- The FSM, counter, error checks and output registers stay in dmem_responder.

Test Plan:
- Store then load, LATENCY=2: req/we=1, addr=0x10, wd=0xDEADBEEF, be=4'hF. Expect stall high for cycles 0–2, ready in cycle 3, err=0. Then a load from 0x10 returns rd=0xDEADBEEF with ready in cycle 3 of that request.
- Byte enables: word 0x20 holds 0x11223344; store wd=0xAABBCCDD with be=4'b0101. A subsequent load of 0x20 returns 0x11BB33DD.
- Errors:
  - Load from addr=0x13 → ready=1, err=1, rd=0.
  - Store to addr=0x400 with DEPTH_WORDS=64 → err=1; reloading word 0 and word 63 shows both unchanged.
- Reset mid-store: store 0xCAFEF00D to 0x8 (word previously 0). Pulse rst low during the first BUSY cycle. Expect ready=0, state back in IDLE, and a later load of 0x8 returns 0x00000000.
- Back-to-back: req held high across two consecutive pipeline requests, loads of 0x0 and 0x4, with LATENCY=1. Expect ready in cycles 2 and 5, and stall low exactly in cycles 2 and 5.
- Input change while BUSY: change addr from 0x10 to 0x14 during BUSY. The returned data must be from 0x10.
